// File: rtl/axi_pkg.sv
// Shared AXI4-Lite response codes and the state encodings used by the
// register-file write and read channel controllers.
package axi_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_regfile_wr_ctrl.sv
// AXI4-Lite write channel controller: accepts AW and W in any order, holds
// whichever arrives first, and issues a single-cycle commit to the register bank.
module axi_lite_wr_ctrl
    import axi_pkg::*;
#(
    parameter int                  ADDR_W   = 32,
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 16,
    parameter int                  IDX_W    = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  commit_en,
    output logic [IDX_W-1:0]      commit_idx,
    output logic [DATA_W-1:0]     commit_data,
    output logic [DATA_W/8-1:0]   commit_strb
);

    localparam int OFFS   = $clog2(DATA_W / 8);
    localparam int STRB_W = DATA_W / 8;

    wr_state_t           state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [STRB_W-1:0]   strb_q;

    logic                aw_hs;
    logic                w_hs;
    logic                commit;
    logic                in_range;
    logic                target_ok;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W-1:0]   word_addr;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // The commit edge is the one completing the later of the two handshakes.
    assign commit = (aw_hs || (state == W_HAVE_A)) && (w_hs || (state == W_HAVE_D));

    assign cur_addr    = (state == W_HAVE_A) ? addr_q : awaddr;
    assign commit_data = (state == W_HAVE_D) ? data_q : wdata;
    assign commit_strb = (state == W_HAVE_D) ? strb_q : wstrb;

    assign word_addr  = cur_addr >> OFFS;
    assign commit_idx = word_addr[IDX_W-1:0];
    assign in_range   = word_addr < ADDR_W'(NUM_REGS);
    assign target_ok  = in_range && !RO_MASK[commit_idx];
    assign commit_en  = commit && target_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (commit) begin
            state   <= W_RESP;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= target_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            case (state)
                W_IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= awaddr;
                        state   <= W_HAVE_A;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                    end else if (w_hs) begin
                        data_q  <= wdata;
                        strb_q  <= wstrb;
                        state   <= W_HAVE_D;
                        awready <= 1'b1;
                        wready  <= 1'b0;
                    end else begin
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                W_HAVE_A, W_HAVE_D: begin
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        state   <= W_IDLE;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: begin
                    state <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register bank with per-register read-only mask, byte strobes,
// SLVERR on illegal access and hardware update ports.
module axi_lite_regfile
    import axi_pkg::*;
#(
    parameter int                  ADDR_W   = 32,
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [DATA_W-1:0]   RST_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [NUM_REGS*DATA_W-1:0]   regs_q,
    output logic [NUM_REGS-1:0]          sw_wr_pulse,
    input  logic [NUM_REGS-1:0]          hw_we,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata
);

    localparam int OFFS   = $clog2(DATA_W / 8);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic                commit_en;
    logic [IDX_W-1:0]    commit_idx;
    logic [DATA_W-1:0]   commit_data;
    logic [STRB_W-1:0]   commit_strb;

    rd_state_t           rd_state;
    logic [ADDR_W-1:0]   ar_word;
    logic [IDX_W-1:0]    ar_idx;
    logic                ar_in_range;

    axi_lite_wr_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .RO_MASK  (RO_MASK)
    ) u_wr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .awaddr      (awaddr),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wvalid      (wvalid),
        .wready      (wready),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready),
        .commit_en   (commit_en),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb)
    );

    // Software commit has priority over hw_we; RO registers never see commit_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RST_VAL;
            end
            sw_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sw_wr_pulse[i] <= commit_en && (commit_idx == IDX_W'(i));
                if (commit_en && (commit_idx == IDX_W'(i))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (commit_strb[b]) begin
                            regs[i][b*8 +: 8] <= commit_data[b*8 +: 8];
                        end
                    end
                end else if (hw_we[i]) begin
                    regs[i] <= hw_wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_q
        assign regs_q[g*DATA_W +: DATA_W] = regs[g];
    end

    assign ar_word     = araddr >> OFFS;
    assign ar_idx      = ar_word[IDX_W-1:0];
    assign ar_in_range = ar_word < ADDR_W'(NUM_REGS);

    // Read data is sampled at the AR handshake, so a same-cycle write commit is not visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rd_state <= R_DATA;
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rdata    <= ar_in_range ? regs[ar_idx] : '0;
                        rresp    <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rd_state <= R_IDLE;
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed vector table, hand-written
// channel-ordering and collision sequences, then random traffic against a register model.
module tb_axi_lite_regfile;

    localparam logic [15:0] RO = 16'h1008;

    logic          clk;
    logic          rst;
    logic [31:0]   awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [31:0]   araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [511:0]  regs_q;
    logic [15:0]   sw_wr_pulse;
    logic [15:0]   hw_we;
    logic [511:0]  hw_wdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [16];

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  expResp;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [12];

    axi_lite_regfile #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NUM_REGS (16),
        .RO_MASK  (RO),
        .RST_VAL  (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .awaddr      (awaddr),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wvalid      (wvalid),
        .wready      (wready),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready),
        .regs_q      (regs_q),
        .sw_wr_pulse (sw_wr_pulse),
        .hw_we       (hw_we),
        .hw_wdata    (hw_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Model rules: word index = addr/4, out of range or RO -> SLVERR with no update.
    function automatic logic [1:0] modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx = int'(addr >> 2);
        if (idx >= 16 || RO[idx]) return 2'b10;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        return 2'b00;
    endfunction

    function automatic logic [1:0] modelRead(input logic [31:0] addr, output logic [31:0] data);
        int idx = int'(addr >> 2);
        if (idx >= 16) begin
            data = 32'h0;
            return 2'b10;
        end
        data = model[idx];
        return 2'b00;
    endfunction

    function automatic logic [31:0] dutReg(input int idx);
        return regs_q[idx*32 +: 32];
    endfunction

    // Entered and left at a negedge; AW and W are raised after independent delays.
    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awDly, input int wDly, output logic [1:0] resp);
        bit awDone = 0;
        bit wDone = 0;
        bit awFire;
        bit wFire;
        int waited = 0;
        int idx = int'(addr >> 2);
        logic [15:0] expP = (idx < 16 && !RO[idx]) ? (16'h1 << idx) : 16'h0;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        bready = 1'b1;
        resp   = 2'b11;
        for (int cyc = 0; cyc < 40 && !(awDone && wDone); cyc++) begin
            if (!awDone && cyc >= awDly) awvalid = 1'b1;
            if (!wDone && cyc >= wDly) wvalid = 1'b1;
            awFire = awvalid && awready;
            wFire  = wvalid && wready;
            @(negedge clk);
            if (awFire) begin awvalid = 1'b0; awDone = 1; end
            if (wFire) begin wvalid = 1'b0; wDone = 1; end
        end
        checkOutput("wr_handshakes_done", 64'(awDone && wDone), 64'(1));
        while (!bvalid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("b_latency", 64'(waited), 64'(0));
        if (bvalid) begin
            resp = bresp;
            checkOutput("sw_wr_pulse", 64'(sw_wr_pulse), 64'(expP));
            @(negedge clk);
            checkOutput("sw_wr_pulse_clear", 64'(sw_wr_pulse), 64'(0));
        end
    endtask

    task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit fired = 0;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        data    = 32'hX;
        resp    = 2'bXX;
        for (int cyc = 0; cyc < 20 && !fired; cyc++) begin
            fired = arvalid && arready;
            @(negedge clk);
        end
        arvalid = 1'b0;
        checkOutput("ar_handshake_done", 64'(fired), 64'(1));
        checkOutput("r_latency", 64'(rvalid), 64'(1));
        if (rvalid) begin
            data = rdata;
            resp = rresp;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int n);
        logic [1:0]  resp;
        logic [31:0] data;
        int idx = int'(v.addr >> 2);
        if (v.isWrite) begin
            axiWrite(v.addr, v.data, v.strb, 0, 0, resp);
            void'(modelWrite(v.addr, v.data, v.strb));
            checkOutput($sformatf("vec%0d_bresp", n), 64'(resp), 64'(v.expResp));
            if (idx < 16) checkOutput($sformatf("vec%0d_reg", n), 64'(dutReg(idx)), 64'(v.expData));
        end else begin
            axiRead(v.addr, data, resp);
            checkOutput($sformatf("vec%0d_rresp", n), 64'(resp), 64'(v.expResp));
            checkOutput($sformatf("vec%0d_rdata", n), 64'(data), 64'(v.expData));
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [1:0]  expResp;
        logic [31:0] data;
        logic [31:0] expData;
        logic [31:0] addr;
        bit          gotR;
        bit          arF;

        vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h40, 32'h11111111, 4'hF, 2'b10, 32'h0};
        vecs[3]  = '{1'b1, 32'h0C, 32'h12345678, 4'hF, 2'b10, 32'h0};
        vecs[4]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[6]  = '{1'b1, 32'h10, 32'hAABBCCDD, 4'h0, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'h0};
        vecs[8]  = '{1'b1, 32'h3E, 32'h0000FFFF, 4'h3, 2'b00, 32'h0000FFFF};
        vecs[9]  = '{1'b0, 32'h3F, 32'h0,        4'h0, 2'b00, 32'h0000FFFF};
        vecs[10] = '{1'b1, 32'h08, 32'h0000AA00, 4'h2, 2'b00, 32'hDEADAAEF};
        vecs[11] = '{1'b0, 32'h0B, 32'h0,        4'h0, 2'b00, 32'hDEADAAEF};

        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; hw_we = '0; hw_wdata = '0;

        #1 rst = 1'b0;
        #1;
        checkOutput("rst_awready", 64'(awready), 64'(0));
        checkOutput("rst_wready", 64'(wready), 64'(0));
        checkOutput("rst_arready", 64'(arready), 64'(0));
        checkOutput("rst_bvalid", 64'(bvalid), 64'(0));
        checkOutput("rst_rvalid", 64'(rvalid), 64'(0));
        checkOutput("rst_bresp", 64'(bresp), 64'(0));
        checkOutput("rst_rresp", 64'(rresp), 64'(0));
        checkOutput("rst_rdata", 64'(rdata), 64'(0));
        checkOutput("rst_pulse", 64'(sw_wr_pulse), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkOutput("ready_before_edge", 64'(awready), 64'(0));
        @(negedge clk);
        checkOutput("ready_aw", 64'(awready), 64'(1));
        checkOutput("ready_w", 64'(wready), 64'(1));
        checkOutput("ready_ar", 64'(arready), 64'(1));
        for (int i = 0; i < 16; i++) checkOutput($sformatf("rst_reg%0d", i), 64'(dutReg(i)), 64'(0));

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

        $display("[TB] W before AW");
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
        checkOutput("wfirst_wready", 64'(wready), 64'(1));
        @(negedge clk);
        wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("have_d_wready", 64'(wready), 64'(0));
            checkOutput("have_d_awready", 64'(awready), 64'(1));
            checkOutput("have_d_no_bvalid", 64'(bvalid), 64'(0));
            @(negedge clk);
        end
        awaddr = 32'h04; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        void'(modelWrite(32'h04, 32'h11223344, 4'b0101));
        checkOutput("wfirst_bvalid", 64'(bvalid), 64'(1));
        checkOutput("wfirst_bresp", 64'(bresp), 64'(0));
        checkOutput("wfirst_reg1", 64'(dutReg(1)), 64'(32'h00220044));
        checkOutput("wfirst_pulse", 64'(sw_wr_pulse), 64'(16'h0002));
        @(negedge clk);
        checkOutput("wfirst_bdone", 64'(bvalid), 64'(0));

        $display("[TB] bready stall with concurrent read");
        awaddr = 32'h18; wdata = 32'h600DF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        void'(modelWrite(32'h18, 32'h600DF00D, 4'hF));
        araddr = 32'h08; arvalid = 1'b1; rready = 1'b1; gotR = 0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("hold_bvalid", 64'(bvalid), 64'(1));
            checkOutput("hold_bresp", 64'(bresp), 64'(0));
            checkOutput("hold_awready", 64'(awready), 64'(0));
            checkOutput("hold_wready", 64'(wready), 64'(0));
            if (rvalid && !gotR) begin
                checkOutput("hold_rdata", 64'(rdata), 64'(model[2]));
                checkOutput("hold_rresp", 64'(rresp), 64'(0));
                gotR = 1;
            end
            arF = arvalid && arready;
            @(negedge clk);
            if (arF) arvalid = 1'b0;
        end
        checkOutput("hold_read_done", 64'(gotR), 64'(1));
        checkOutput("hold_reg6", 64'(dutReg(6)), 64'(model[6]));
        bready = 1'b1;
        @(negedge clk);
        checkOutput("stall_bdone", 64'(bvalid), 64'(0));
        checkOutput("stall_awready", 64'(awready), 64'(1));

        $display("[TB] hardware write ports and collisions");
        hw_we[5] = 1'b1; hw_wdata[5*32 +: 32] = 32'h55AA55AA;
        hw_we[3] = 1'b1; hw_wdata[3*32 +: 32] = 32'h0000C0DE;
        @(negedge clk);
        hw_we = '0;
        model[5] = 32'h55AA55AA;
        model[3] = 32'h0000C0DE;
        checkOutput("hw_reg5", 64'(dutReg(5)), 64'(model[5]));
        checkOutput("hw_ro_reg3", 64'(dutReg(3)), 64'(model[3]));
        awaddr = 32'h14; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        hw_we[5] = 1'b1; hw_wdata[5*32 +: 32] = 32'hCAFEF00D;
        araddr = 32'h14; arvalid = 1'b1; rready = 1'b0; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; hw_we = '0;
        expData = model[5];
        void'(modelWrite(32'h14, 32'h12345678, 4'hF));
        checkOutput("coll_reg5", 64'(dutReg(5)), 64'(model[5]));
        checkOutput("coll_bvalid", 64'(bvalid), 64'(1));
        checkOutput("coll_rvalid", 64'(rvalid), 64'(1));
        checkOutput("coll_old_rdata", 64'(rdata), 64'(expData));
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            addr = ($urandom_range(0, 19) * 4) + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                axiWrite(addr, data, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), resp);
                expResp = modelWrite(addr, data, wstrb);
                checkOutput("rand_bresp", 64'(resp), 64'(expResp));
                if (int'(addr >> 2) < 16)
                    checkOutput("rand_reg", 64'(dutReg(int'(addr >> 2))), 64'(model[int'(addr >> 2)]));
            end else begin
                axiRead(addr, data, resp);
                expResp = modelRead(addr, expData);
                checkOutput("rand_rresp", 64'(resp), 64'(expResp));
                checkOutput("rand_rdata", 64'(data), 64'(expData));
            end
        end
        for (int i = 0; i < 16; i++) checkOutput($sformatf("final_reg%0d", i), 64'(dutReg(i)), 64'(model[i]));

        $display("[TB] reset during write");
        awaddr = 32'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("midrst_bvalid", 64'(bvalid), 64'(0));
        checkOutput("midrst_awready", 64'(awready), 64'(0));
        checkOutput("midrst_wready", 64'(wready), 64'(0));
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_awready", 64'(awready), 64'(1));
        checkOutput("post_rst_wready", 64'(wready), 64'(1));
        checkOutput("post_rst_arready", 64'(arready), 64'(1));
        checkOutput("post_rst_bvalid", 64'(bvalid), 64'(0));
        for (int i = 0; i < 16; i++) checkOutput($sformatf("post_rst_reg%0d", i), 64'(dutReg(i)), 64'(model[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
